regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two writers:
//  the main pipeline writeback stage and a long-latency unit (mul/div, or a load unit).
//  The long-latency unit's writes are buffered in a FIFO.
//  An anti-starvation timer briefly stalls the pipeline so buffered writes always drain.
//  Sits between the writeback stage, the long-latency unit and the register file.
// PARAMETERS
//  DEPTH     2  long-latency write FIFO entries; power of 2, >=2
//  MAX_WAIT  4  cycles a non-empty FIFO head may wait before forced priority; >=1
// PORTS
//  CLK         in   1   clock, all state updates on posedge
//  Reset       in   1   synchronous, active-high reset
//  pipe_valid  in   1   pipeline has a writeback this cycle
//  pipe_rd     in   5   pipeline destination register
//  pipe_data   in   32  pipeline writeback data
//  pipe_ready  out  1   pipeline write accepted this cycle; 0 = pipeline must stall and hold
//  lu_valid    in   1   long-latency unit offers a result
//  lu_rd       in   5   long-latency destination register
//  lu_data     in   32  long-latency result data
//  lu_ready    out  1   FIFO can accept (count < DEPTH)
//  WE3         out  1   register file write enable (registered)
//  A3          out  5   register file write address (registered)
//  WD3         out  32  register file write data (registered)
//  fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//  Reset, sampled on a CLK edge:
//   - WE3=0, A3=0, WD3=0; FIFO emptied (contents discarded); wait_cnt=0; state=NORMAL.
//   - A registered write already in flight is dropped.
//   - While Reset=1: pipe_ready=0 and lu_ready=0.
//  Push: lu_valid & lu_ready.
//   - lu_ready uses the occupancy before any same-cycle pop.
//   - When full, nothing is pushed even if the FIFO pops in the same cycle.
//  FSM, 2 states:
//   - NORMAL: pipe_ready=1.
//     Grant goes to the pipeline if pipe_valid; otherwise to the FIFO head if count>0 (pop).
//   - STARVE: pipe_ready=0; grant goes to the FIFO head (pop).
//     Return to NORMAL on the next edge.
//  wait_cnt:
//   - Increments each cycle the FIFO is non-empty and its head is not granted.
//   - Clears on any pop, or when the FIFO is empty.
//   - NORMAL->STARVE when wait_cnt reaches MAX_WAIT-1 while the head is still blocked.
//  Output register:
//   - The granted write appears on WE3/A3/WD3 one cycle after the grant.
//   - No grant -> WE3=0; A3/WD3 hold their previous values.
//  rd==0 writes (either source):
//   - Grant consumed (pop/accept happens) but WE3=0, so x0 is never written.
//  Latency:
//   - Pipeline accepted at cycle t -> WE3 at t+1.
//   - LU pushed at t into an empty FIFO, with no pipeline write at t+1 -> WE3 at t+2.
//   - No same-cycle bypass from lu_* to the write port.
//  Ordering:
//   - FIFO is strictly in order.
//   - No cross-port same-rd ordering is enforced; the issue/hazard logic guarantees it.
//  Simultaneous push and pop: allowed when not full; count unchanged.
//  Pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
// TESTING
//  1. pipe_valid=1, rd=5, data=0xDEADBEEF; FIFO empty
//     -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
//  2. lu push rd=7, data=0x12 with pipe idle
//     -> fifo_count=1 next cycle; WE3=1, A3=7 one cycle after that; count back to 0.
//  3. pipe_valid held 1 continuously; one lu entry queued
//     -> pipe_ready=0 for exactly 1 cycle, after 4 blocked cycles (MAX_WAIT=4).
//     -> The lu write is issued, then pipeline writes resume in order.
//  4. Push 3 lu entries back-to-back with pipe busy
//     -> lu_ready=0 after 2 pushes; 3rd held.
//     -> All 3 written eventually in push order.
//  5. pipe write rd=0, data=0xFFFF -> pipe_ready=1, WE3 stays 0.
//  6. Reset asserted with 2 FIFO entries and a pending write
//     -> next edge WE3=0, fifo_count=0; no entry ever written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the pipeline writeback stage and a
// FIFO-buffered long-latency unit, with a starvation timer that forces the FIFO to drain.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         pipe_valid,
  input  logic [4:0]                   pipe_rd,
  input  logic [31:0]                  pipe_data,
  output logic                         pipe_ready,
  input  logic                         lu_valid,
  input  logic [4:0]                   lu_rd,
  input  logic [31:0]                  lu_data,
  output logic                         lu_ready,
  output logic                         WE3,
  output logic [4:0]                   A3,
  output logic [31:0]                  WD3,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT) + 1;

  localparam logic [CntW-1:0]  DepthC    = CntW'(DEPTH);
  localparam logic [WaitW-1:0] WaitLastC = WaitW'(MAX_WAIT - 1);

  typedef enum logic {StNormal, StStarve} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [4:0]        rd_mem_q [DEPTH];
  logic [31:0]       data_mem_q [DEPTH];
  logic              we_q, we_d;
  logic [4:0]        a_q, a_d;
  logic [31:0]       wd_q, wd_d;

  logic        nonempty;
  logic        push;
  logic        pop;
  logic        grant_pipe;
  logic        head_blocked;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;

  always_comb begin
    pipe_ready   = 1'b0;
    lu_ready     = 1'b0;
    grant_pipe   = 1'b0;
    pop          = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    count_d      = count_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    we_d         = 1'b0;
    a_d          = a_q;
    wd_d         = wd_q;
    grant_rd     = 5'd0;
    grant_data   = 32'd0;

    nonempty = (count_q != '0);
    // Acceptance uses pre-pop occupancy: a full FIFO never pushes, even while popping.
    lu_ready = !Reset && (count_q < DepthC);
    push     = lu_valid && lu_ready;

    unique case (state_q)
      StNormal: begin
        pipe_ready = !Reset;
        if (pipe_valid) begin
          grant_pipe = 1'b1;
        end else begin
          pop = nonempty;
        end
      end
      StStarve: begin
        pop = nonempty;
      end
      default: ;
    endcase

    head_blocked = nonempty && !pop;

    if (pop || !nonempty) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + WaitW'(1);
    end

    unique case (state_q)
      StNormal: if (head_blocked && (wait_q == WaitLastC)) state_d = StStarve;
      StStarve: state_d = StNormal;
      default:  state_d = StNormal;
    endcase

    if (grant_pipe) begin
      grant_rd   = pipe_rd;
      grant_data = pipe_data;
    end else if (pop) begin
      grant_rd   = rd_mem_q[rptr_q];
      grant_data = data_mem_q[rptr_q];
    end

    // x0 writes still consume their grant but never assert the write enable.
    if ((grant_pipe || pop) && (grant_rd != 5'd0)) begin
      we_d = 1'b1;
      a_d  = grant_rd;
      wd_d = grant_data;
    end

    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StNormal;
      wait_q  <= '0;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      we_q    <= 1'b0;
      a_q     <= 5'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= lu_rd;
      data_mem_q[wptr_q] <= lu_data;
    end
  end

  assign WE3        = we_q;
  assign A3         = a_q;
  assign WD3        = wd_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        CLK;
  logic        Reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [1:0]  fifo_count;

  regfile_wb_arbiter #(
    .DEPTH   (DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .pipe_valid(pipe_valid),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .pipe_ready(pipe_ready),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .fifo_count(fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending LU writes, cycles the head has waited, forced-drain flag.
  logic [36:0] mq[$];
  int          m_wait   = 0;
  bit          m_starve = 0;
  logic        m_we     = 1'b0;
  logic [4:0]  m_a      = 5'd0;
  logic [31:0] m_wd     = 32'd0;

  logic [4:0]  wlog[$];
  logic        last_pr;
  logic        last_lr;

  task automatic check_eq(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic pv, input logic [4:0] prd,
                            input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                            input logic [31:0] ld);
    int          sz;
    bit          pop;
    bit          wr;
    bit          go_starve;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [36:0] head;
    if (r) begin
      mq.delete();
      m_wait   = 0;
      m_starve = 0;
      m_we     = 1'b0;
      m_a      = 5'd0;
      m_wd     = 32'd0;
      return;
    end
    sz   = mq.size();
    pop  = 0;
    wr   = 0;
    wrd  = 5'd0;
    wdat = 32'd0;
    if (!m_starve && pv) begin
      wr   = 1;
      wrd  = prd;
      wdat = pd;
    end else if (sz > 0) begin
      pop  = 1;
      head = mq.pop_front();
      wr   = 1;
      wrd  = head[36:32];
      wdat = head[31:0];
    end
    go_starve = !m_starve && (sz > 0) && !pop && (m_wait == MAX_WAIT - 1);
    m_wait    = (pop || sz == 0) ? 0 : m_wait + 1;
    if (lv && sz < DEPTH) mq.push_back({lrd, ld});
    m_starve = go_starve;
    m_we     = wr && (wrd != 5'd0);
    if (m_we) begin
      m_a  = wrd;
      m_wd = wdat;
    end
  endtask

  task automatic step(input logic r, input logic pv, input logic [4:0] prd,
                      input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld);
    Reset      = r;
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    lu_valid   = lv;
    lu_rd      = lrd;
    lu_data    = ld;
    #1;
    check_eq("pipe_ready", 37'(pipe_ready), 37'(!r && !m_starve));
    check_eq("lu_ready", 37'(lu_ready), 37'(!r && (mq.size() < DEPTH)));
    last_pr = pipe_ready;
    last_lr = lu_ready;
    @(posedge CLK);
    model_edge(r, pv, prd, pd, lv, lrd, ld);
    #1;
    check_eq("WE3", 37'(WE3), 37'(m_we));
    check_eq("A3", 37'(A3), 37'(m_a));
    check_eq("WD3", 37'(WD3), 37'(m_wd));
    check_eq("fifo_count", 37'(fifo_count), 37'(mq.size()));
    if (WE3 === 1'b1) wlog.push_back(A3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int lows;
    int first_low;
    int idx;
    int hits;
    logic [4:0] ord[$];

    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2);
    check_eq("reset_we", 37'(WE3), 37'(0));
    check_eq("reset_count", 37'(fifo_count), 37'(0));

    // Basic pipeline write.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check_eq("t1_we", 37'(WE3), 37'(1));
    check_eq("t1_a3", 37'(A3), 37'(5));
    check_eq("t1_wd3", 37'(WD3), 37'(32'hDEADBEEF));

    // LU write through an empty FIFO with the pipe idle.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12);
    check_eq("t2_count1", 37'(fifo_count), 37'(1));
    check_eq("t2_we_early", 37'(WE3), 37'(0));
    idle(1);
    check_eq("t2_we", 37'(WE3), 37'(1));
    check_eq("t2_a3", 37'(A3), 37'(7));
    check_eq("t2_count0", 37'(fifo_count), 37'(0));

    // Continuous pipe traffic with one queued LU entry: forced single-cycle stall.
    lows = 0;
    first_low = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 5'(i + 1), 32'(i), i == 0, 5'd9, 32'h99);
      if (!last_pr) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
    end
    check_eq("t3_stall_cycles", 37'(lows), 37'(1));
    check_eq("t3_stall_index", 37'(first_low), 37'(5));

    // Three back-to-back LU pushes with the pipe busy.
    wlog.delete();
    idx = 0;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      step(1'b0, 1'b1, 5'd3, 32'(k), 1'b1, 5'(10 + idx), 32'(100 + idx));
      if (k == 2) check_eq("t4_lu_ready_full", 37'(last_lr), 37'(0));
      if (last_lr) idx++;
    end
    check_eq("t4_all_pushed", 37'(idx), 37'(3));
    idle(6);
    ord.delete();
    foreach (wlog[j]) if (wlog[j] >= 5'd10 && wlog[j] <= 5'd12) ord.push_back(wlog[j]);
    check_eq("t4_nwritten", 37'(ord.size()), 37'(3));
    for (int j = 0; j < 3; j++) begin
      if (j < ord.size()) check_eq("t4_order", 37'(ord[j]), 37'(10 + j));
    end

    // x0 writes are accepted but never enable the write port.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    check_eq("t5_pipe_ready", 37'(last_pr), 37'(1));
    check_eq("t5_we", 37'(WE3), 37'(0));

    // Reset with two queued entries and a write in flight.
    step(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd20, 32'd20);
    step(1'b0, 1'b1, 5'd4, 32'd2, 1'b1, 5'd21, 32'd21);
    check_eq("t6_pre_count", 37'(fifo_count), 37'(2));
    step(1'b1, 1'b1, 5'd6, 32'd3, 1'b0, 5'd0, 32'd0);
    check_eq("t6_we", 37'(WE3), 37'(0));
    check_eq("t6_count", 37'(fifo_count), 37'(0));
    wlog.delete();
    idle(8);
    hits = 0;
    foreach (wlog[j]) if (wlog[j] == 5'd20 || wlog[j] == 5'd21) hits++;
    check_eq("t6_no_stale", 37'(hits), 37'(0));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 55), 5'($urandom),
           $urandom, ($urandom_range(0, 99) < 40), 5'($urandom), $urandom);
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
